// File: rtl/randlog_pkg.sv
// Shared constants and FSM encoding for the randlog scheduler and related
// shared-resource blocks.
package randlog_pkg;

   localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
   // LFSR stage + BRAM address register + result register
   localparam int          RNG_LATENCY  = 3;
   localparam int          SAMPLE_W     = 32;

   typedef logic [1:0] state_t;
   localparam state_t ST_SEEDING = 2'd0;
   localparam state_t ST_WARMUP  = 2'd1;
   localparam state_t ST_RUN     = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or above ptr,
// wrapping to the lowest eligible index when nothing sits above ptr.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] eligible,
   input  logic [PW-1:0]    ptr,
   output logic [PW-1:0]    winner,
   output logic             any_valid
);

   logic [N_REQ-1:0] upper_mask;
   logic [N_REQ-1:0] masked;
   logic [PW-1:0]    hi_idx;
   logic [PW-1:0]    lo_idx;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
         assign upper_mask[gi] = (PW'(gi) >= ptr);
      end
   endgenerate

   assign masked = eligible & upper_mask;

   // Descending scan leaves the lowest set index in each result.
   always_comb begin
      hi_idx = '0;
      lo_idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (masked[i])   hi_idx = PW'(i);
         if (eligible[i]) lo_idx = PW'(i);
      end
   end

   assign winner    = (|masked) ? hi_idx : lo_idx;
   assign any_valid = |eligible;

endmodule

// File: rtl/randlog_sched.sv
// Seeds, warms up and then round-robins one randlog sample stream between
// N_REQ requesters, one grant per clock.
module randlog_sched #(
   parameter int          N_REQ        = 4,
   parameter int          RST_CYCLES   = 2,
   parameter int          WARMUP       = randlog_pkg::RNG_LATENCY,
   parameter logic [15:0] SEED_DEFAULT = randlog_pkg::SEED_DEFAULT
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            reseed,
   input  logic [15:0]                     seed_in,
   output logic                            rng_rst,
   output logic [15:0]                     rng_seed,
   input  logic [randlog_pkg::SAMPLE_W-1:0] rng_result,
   input  logic [N_REQ-1:0]                req,
   output logic [N_REQ-1:0]                ack,
   output logic [randlog_pkg::SAMPLE_W-1:0] sample,
   output logic                            ready,
   output logic [31:0]                     sample_count
);
   import randlog_pkg::*;

   localparam int PW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int PH_MAX = (RST_CYCLES > WARMUP) ? RST_CYCLES : WARMUP;
   localparam int PH_W   = $clog2(PH_MAX + 1);

   state_t                state_reg;
   logic [PH_W-1:0]       phase_reg;
   logic [15:0]           seed_reg;
   logic [N_REQ-1:0]      ack_reg;
   logic [SAMPLE_W-1:0]   sample_reg;
   logic [PW-1:0]         ptr_reg;
   logic [31:0]           sample_count_reg;

   logic [N_REQ-1:0]      eligible;
   logic [PW-1:0]         winner;
   logic                  any_valid;
   logic [PW-1:0]         ptr_next;

   // A requester acked this cycle sits out one round so its req can drop.
   assign eligible = req & ~ack_reg;

   rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
      .eligible  (eligible),
      .ptr       (ptr_reg),
      .winner    (winner),
      .any_valid (any_valid)
   );

   assign ptr_next = (winner == PW'(N_REQ - 1)) ? '0 : winner + PW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= ST_SEEDING;
         phase_reg        <= '0;
         seed_reg         <= SEED_DEFAULT;
         ack_reg          <= '0;
         sample_reg       <= '0;
         ptr_reg          <= '0;
         sample_count_reg <= '0;
      end else begin
         ack_reg <= '0;
         if (reseed) begin
            // A zero seed would lock the LFSR, so fall back to the default.
            state_reg <= ST_SEEDING;
            phase_reg <= '0;
            seed_reg  <= (seed_in == 16'h0000) ? SEED_DEFAULT : seed_in;
         end else begin
            case (state_reg)
               ST_SEEDING: begin
                  if (phase_reg == PH_W'(RST_CYCLES - 1)) begin
                     state_reg <= ST_WARMUP;
                     phase_reg <= '0;
                  end else begin
                     phase_reg <= phase_reg + PH_W'(1);
                  end
               end
               ST_WARMUP: begin
                  if (phase_reg == PH_W'(WARMUP - 1)) begin
                     state_reg <= ST_RUN;
                     phase_reg <= '0;
                  end else begin
                     phase_reg <= phase_reg + PH_W'(1);
                  end
               end
               ST_RUN: begin
                  if (any_valid) begin
                     ack_reg    <= N_REQ'(1) << winner;
                     sample_reg <= rng_result;
                     ptr_reg    <= ptr_next;
                     if (sample_count_reg != 32'hFFFF_FFFF)
                        sample_count_reg <= sample_count_reg + 32'd1;
                  end
               end
               default: begin
                  state_reg <= ST_SEEDING;
                  phase_reg <= '0;
               end
            endcase
         end
      end
   end

   assign rng_rst      = (state_reg == ST_SEEDING);
   assign rng_seed     = seed_reg;
   assign ready        = (state_reg == ST_RUN);
   assign ack          = ack_reg;
   assign sample       = sample_reg;
   assign sample_count = sample_count_reg;

endmodule
